// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-N counter with load, cascade carry and wrap pulse; MOD_COUNTER_DOWN_EN adds dir (up/down)
module mod_counter #(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MODULUS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
`ifdef MOD_COUNTER_DOWN_EN
  input  logic             dir,
`endif
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             wrap,
  output logic             load_err
);

  localparam longint unsigned FULL_RANGE = 64'd1 << WIDTH;
  // A full 2^WIDTH modulus wraps through natural overflow of the extra bit
  localparam bit              POW2       = (MODULUS == FULL_RANGE);
  localparam logic [WIDTH-1:0] LAST      = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   ONE_EXT   = {{WIDTH{1'b0}}, 1'b1};

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter: WIDTH must be in 1..32");
  end
  if (MODULUS < 64'd2 || MODULUS > FULL_RANGE) begin : g_bad_modulus
    $error("mod_counter: MODULUS must be in 2..2^WIDTH");
  end

  typedef enum logic {HOLD = 1'b0, COUNTING = 1'b1} mode_t;

  mode_t            mode;
  logic             up;
  logic [WIDTH:0]   inc;
  logic [WIDTH:0]   dec;
  logic             up_wrap;
  logic             down_wrap;
  logic [WIDTH-1:0] step_val;
  logic             step_wrap;
  logic             terminal;
  logic             load_ok;

  // Per-cycle mode, next count on a step, terminal detect and cascade carry
  always_comb begin
    mode      = HOLD;
    up        = 1'b1;
    inc       = '0;
    dec       = '0;
    up_wrap   = 1'b0;
    down_wrap = 1'b0;
    step_val  = count;
    step_wrap = 1'b0;
    terminal  = 1'b0;
    load_ok   = 1'b0;
    carry     = 1'b0;

    if (enable) mode = COUNTING;
`ifdef MOD_COUNTER_DOWN_EN
    up = dir;
`endif
    inc       = {1'b0, count} + ONE_EXT;
    dec       = {1'b0, count} - ONE_EXT;
    up_wrap   = POW2 ? inc[WIDTH] : (count == LAST);
    down_wrap = dec[WIDTH];

    if (up) begin
      step_val  = up_wrap ? '0 : inc[WIDTH-1:0];
      step_wrap = up_wrap;
      terminal  = (count == LAST);
    end else begin
      step_val  = down_wrap ? LAST : dec[WIDTH-1:0];
      step_wrap = down_wrap;
      terminal  = (count == '0);
    end

    load_ok = ({1'b0, load_val} < MOD_EXT);
    carry   = (mode == COUNTING) && terminal && !rst && !load;
  end

  // Count register and one-cycle wrap / load_err pulses; rst > load > enable > hold
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      count    <= load_ok ? load_val : LAST;
      wrap     <= 1'b0;
      load_err <= !load_ok;
    end else if (mode == COUNTING) begin
      count    <= step_val;
      wrap     <= step_wrap;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - directed self-checking bench for mod_counter
module tb_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // WIDTH=8, MODULUS=256 instance
  logic       rst8 = 1'b1, en8 = 1'b0, ld8 = 1'b0, dir8 = 1'b1;
  logic [7:0] lv8 = '0, cnt8;
  logic       carry8, wrap8, lerr8;

  // WIDTH=4, MODULUS=10 instance
  logic       rst10 = 1'b1, en10 = 1'b0, ld10 = 1'b0, dir10 = 1'b1;
  logic [3:0] lv10 = '0, cnt10;
  logic       carry10, wrap10, lerr10;

  // Two-stage MODULUS=10 cascade
  logic       rstc = 1'b1, enc = 1'b0, dirc = 1'b1;
  logic [3:0] c0, c1;
  logic       carry0, carry1, wrapc0, wrapc1, lerrc0, lerrc1;

  mod_counter #(.WIDTH(8), .MODULUS(256)) u_c8 (
    .clk(clk), .rst(rst8), .enable(en8),
`ifdef MOD_COUNTER_DOWN_EN
    .dir(dir8),
`endif
    .load(ld8), .load_val(lv8), .count(cnt8), .carry(carry8), .wrap(wrap8), .load_err(lerr8)
  );

  mod_counter #(.WIDTH(4), .MODULUS(10)) u_c10 (
    .clk(clk), .rst(rst10), .enable(en10),
`ifdef MOD_COUNTER_DOWN_EN
    .dir(dir10),
`endif
    .load(ld10), .load_val(lv10), .count(cnt10), .carry(carry10), .wrap(wrap10), .load_err(lerr10)
  );

  mod_counter #(.WIDTH(4), .MODULUS(10)) u_s0 (
    .clk(clk), .rst(rstc), .enable(enc),
`ifdef MOD_COUNTER_DOWN_EN
    .dir(dirc),
`endif
    .load(1'b0), .load_val(4'd0), .count(c0), .carry(carry0), .wrap(wrapc0), .load_err(lerrc0)
  );

  mod_counter #(.WIDTH(4), .MODULUS(10)) u_s1 (
    .clk(clk), .rst(rstc), .enable(carry0),
`ifdef MOD_COUNTER_DOWN_EN
    .dir(dirc),
`endif
    .load(1'b0), .load_val(4'd0), .count(c1), .carry(carry1), .wrap(wrapc1), .load_err(lerrc1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp8, prev8, exp10, wraps10, n;

    // Reset state of every instance
    step();
    check("rst_cnt8", cnt8, 0);
    check("rst_wrap8", wrap8, 0);
    check("rst_lerr8", lerr8, 0);
    check("rst_cnt10", cnt10, 0);
    check("rst_c0", c0, 0);
    check("rst_c1", c1, 0);

    // 300 enabled cycles at MODULUS=256
    rst8 = 1'b0;
    en8  = 1'b1;
    exp8 = 0;
    for (int i = 0; i < 300; i++) begin
      check("carry8", carry8, (exp8 == 255) ? 1 : 0);
      step();
      prev8 = exp8;
      exp8  = (exp8 + 1) % 256;
      check("cnt8", cnt8, exp8);
      check("wrap8", wrap8, (prev8 == 255) ? 1 : 0);
    end
    check("cnt8_end", cnt8, 44);

    // Hold keeps count and clears wrap
    en8 = 1'b0;
    step();
    check("hold_cnt8", cnt8, 44);
    check("hold_wrap8", wrap8, 0);

    // 25 enabled cycles at MODULUS=10
    rst10   = 1'b0;
    en10    = 1'b1;
    exp10   = 0;
    wraps10 = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      exp10 = (exp10 + 1) % 10;
      check("cnt10", cnt10, exp10);
      if (wrap10 === 1'b1) wraps10++;
      check("cnt10_le9", (cnt10 <= 4'd9) ? 1 : 0, 1);
    end
    check("wraps10", wraps10, 2);
    check("cnt10_end", cnt10, 5);

    // Load 9, then load 7 with enable high: load wins, no carry, no wrap
    en10 = 1'b0; ld10 = 1'b1; lv10 = 4'd9;
    step();
    check("ld9_cnt", cnt10, 9);
    en10 = 1'b1; lv10 = 4'd7;
    check("ld_carry_forced0", carry10, 0);
    step();
    check("ld7_cnt", cnt10, 7);
    check("ld7_wrap", wrap10, 0);
    check("ld7_lerr", lerr10, 0);

    // Out-of-range loads saturate to MODULUS-1 and pulse load_err once
    en10 = 1'b0; lv10 = 4'd12;
    step();
    check("ld12_cnt", cnt10, 9);
    check("ld12_lerr", lerr10, 1);
    check("ld12_wrap", wrap10, 0);
    ld10 = 1'b0;
    step();
    check("lerr_one_cycle", lerr10, 0);
    check("hold_cnt10", cnt10, 9);
    ld10 = 1'b1; lv10 = 4'd10;
    step();
    check("ld10_cnt", cnt10, 9);
    check("ld10_lerr", lerr10, 1);

    // Reset clears a pending load_err and beats a simultaneous load
    rst10 = 1'b1; lv10 = 4'd3;
    step();
    check("rst_ld_cnt", cnt10, 0);
    check("rst_clr_lerr", lerr10, 0);
    rst10 = 1'b0; ld10 = 1'b0;

`ifdef MOD_COUNTER_DOWN_EN
    // Down count from 1: 0, 9 (wrap), 8
    ld10 = 1'b1; lv10 = 4'd1; dir10 = 1'b0;
    step();
    ld10 = 1'b0; en10 = 1'b1;
    check("dn_carry_at1", carry10, 0);
    step();
    check("dn_cnt0", cnt10, 0);
    check("dn_carry_at0", carry10, 1);
    step();
    check("dn_cnt9", cnt10, 9);
    check("dn_wrap", wrap10, 1);
    check("dn_carry_at9", carry10, 0);
    step();
    check("dn_cnt8", cnt10, 8);
    check("dn_wrap_clear", wrap10, 0);
    en10 = 1'b0; dir10 = 1'b1;
`endif

    // Cascade: 123 cycles gives tens=2, units=3
    rstc = 1'b0;
    enc  = 1'b1;
    n    = 0;
    for (int i = 0; i < 123; i++) begin
      step();
      n++;
      check("casc_c0", c0, n % 10);
      check("casc_c1", c1, (n / 10) % 10);
    end
    check("casc_end_c0", c0, 3);
    check("casc_end_c1", c1, 2);

    // Reset at cycle 60 of a fresh run clears both stages on the next edge
    rstc = 1'b1;
    step();
    rstc = 1'b0;
    for (int i = 0; i < 60; i++) step();
    check("casc60_c0", c0, 0);
    check("casc60_c1", c1, 6);
    rstc = 1'b1;
    step();
    check("casc_rst_c0", c0, 0);
    check("casc_rst_c1", c1, 0);
    rstc = 1'b0;
    step();
    check("casc_restart_c0", c0, 1);
    check("casc_restart_c1", c1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
